// File: rtl/shifter_sll_seq.sv
// Sequential 32-bit logical-left shifter for SLL/SLLV: resolves one shift-amount
// bit per clock through a single 1/2/4/8/16 stage, with a start/busy/done handshake.
module shifter_sll_seq #(
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t      state;
    logic [31:0] w;
    logic [4:0]  sh;
    logic [2:0]  k;

    logic [31:0] stage_shift;
    logic [31:0] w_next;
    logic [4:0]  sh_rem;
    logic        last_stage;

    // Only dataB[4:0] carries the shift amount.
    logic unused_dataB_hi;
    assign unused_dataB_hi = ^dataB[31:5];

    // One shared stage: k selects a shift of 2^k, applied only when sh[k] is set.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        stage_shift = w;
        case (k)
            3'd0:    stage_shift = {w[30:0], 1'b0};
            3'd1:    stage_shift = {w[29:0], 2'b0};
            3'd2:    stage_shift = {w[27:0], 4'b0};
            3'd3:    stage_shift = {w[23:0], 8'b0};
            default: stage_shift = {w[15:0], 16'b0};
        endcase
        w_next     = sh[k] ? stage_shift : w;
        sh_rem     = sh >> k;
        last_stage = (k == 3'd4) || (EARLY_EXIT && (sh_rem[4:1] == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            w       <= '0;
            sh      <= '0;
            k       <= '0;
            dataOut <= '0;
            done    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        w     <= dataA;
                        sh    <= dataB[4:0];
                        k     <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    w <= w_next;
                    k <= k + 3'd1;
                    if (last_stage) begin
                        dataOut <= w_next;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);

endmodule

// File: tb/tb_shifter_sll_seq.sv
// Self-checking bench: drives both EARLY_EXIT variants with shared stimulus and
// scoreboards every done pulse against a << b[4:0] and the expected latency.
module tb_shifter_sll_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [31:0] data_out0, data_out1;
    logic        busy0, busy1;
    logic        done0, done1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [31:0] data;
        int          acc;
        int          n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shifter_sll_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .dataA(data_a), .dataB(data_b),
        .dataOut(data_out0), .busy(busy0), .done(done0)
    );

    shifter_sll_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .dataA(data_a), .dataB(data_b),
        .dataOut(data_out1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
        checks++;
        assert (obs === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expected);
        end
    endtask

    function automatic int lat_ee(input logic [31:0] b);
        int n = 1;
        for (int i = 0; i < 5; i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one start pulse (accepted on the next edge) and queues the expected results.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start  = 1'b1;
        data_a = a;
        data_b = b;
        e.data = a << b[4:0];
        e.acc  = cyc + 1;
        e.n    = 5;
        q0.push_back(e);
        e.n    = lat_ee(b);
        q1.push_back(e);
        tick();
        start  = 1'b0;
        data_a = $urandom;
        data_b = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy0 || busy1) && t < 40) begin
            tick();
            t++;
        end
        check("idle_reached", {31'b0, busy0 | busy1}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            check("dut0_done_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                m0 = q0.pop_front();
                check("dut0_data", data_out0, m0.data);
                check("dut0_latency", 32'(cyc - m0.acc), 32'(m0.n));
            end
        end
        if (done1 === 1'b1) begin
            check("dut1_done_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                m1 = q1.pop_front();
                check("dut1_data", data_out1, m1.data);
                check("dut1_latency", 32'(cyc - m1.acc), 32'(m1.n));
            end
        end
    end

    initial begin
        int t;
        reset  = 1'b1;
        start  = 1'b0;
        data_a = '0;
        data_b = '0;
        tick();
        tick();
        check("rst_data0", data_out0, 32'h0);
        check("rst_busy0", {31'b0, busy0}, 32'd0);
        check("rst_done0", {31'b0, done0}, 32'd0);
        check("rst_data1", data_out1, 32'h0);
        check("rst_busy1", {31'b0, busy1}, 32'd0);
        check("rst_done1", {31'b0, done1}, 32'd0);
        reset = 1'b0;
        tick();

        // Full-range shift: busy for exactly five cycles after the accepting edge.
        launch(32'h0000_0001, 32'd31);
        for (int i = 0; i < 5; i++) begin
            check("full_busy", {31'b0, busy0}, 32'd1);
            tick();
        end
        check("full_busy_end", {31'b0, busy0}, 32'd0);
        check("full_done", {31'b0, done0}, 32'd1);
        check("full_data", data_out0, 32'h8000_0000);
        wait_idle();

        // Upper dataB bits must be ignored.
        launch(32'h1234_5678, 32'hFFFF_FFE4);
        wait_idle();
        check("upper_ign0", data_out0, 32'h2345_6780);
        check("upper_ign1", data_out1, 32'h2345_6780);

        // Zero shift exits after one stage with early exit.
        launch(32'hFFFF_FFFF, 32'd0);
        tick();
        check("zero_done1", {31'b0, done1}, 32'd1);
        check("zero_data1", data_out1, 32'hFFFF_FFFF);
        wait_idle();
        launch(32'hFFFF_FFFF, 32'd16);
        wait_idle();
        check("sh16_data1", data_out1, 32'hFFFF_0000);

        // Start while busy is dropped; start in the done cycle is accepted.
        launch(32'h0000_0001, 32'd31);
        tick();
        start  = 1'b1;
        data_a = 32'hA;
        data_b = 32'd1;
        tick();
        start  = 1'b0;
        t = 0;
        while (!done0 && t < 20) begin
            tick();
            t++;
        end
        check("b2b_first_done", {31'b0, done0}, 32'd1);
        launch(32'h0000_0003, 32'd2);
        wait_idle();
        check("b2b_data0", data_out0, 32'h0000_000C);
        check("b2b_data1", data_out1, 32'h0000_000C);

        // Reset mid-operation discards the in-flight result.
        launch(32'h0000_0001, 32'd31);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        q0.delete();
        q1.delete();
        check("mid_rst_busy0", {31'b0, busy0}, 32'd0);
        check("mid_rst_data0", data_out0, 32'h0);
        check("mid_rst_busy1", {31'b0, busy1}, 32'd0);
        check("mid_rst_data1", data_out1, 32'h0);
        repeat (8) tick();
        launch(32'h0000_0005, 32'd3);
        wait_idle();
        check("post_rst_data0", data_out0, 32'h0000_0028);

        // Random operands on both variants; the monitor checks value and latency.
        for (int i = 0; i < 4000; i++) begin
            launch($urandom, $urandom);
            wait_idle();
        end

        tick();
        tick();
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
